// File: rtl/imem_loader_if.sv
// Signal bundle between the byte-stream source / CPU side and the instruction-memory loader.
// The loader takes the slave view; the stream source and test harness take the master view.
interface imem_loader_if #(
    parameter int ADDR_W = 7
);
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic              abort;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [31:0]       wr_address;
    logic [31:0]       wr_data;
    logic              busy;
    logic              cpu_stall;
    logic              done;

    modport master (
        output start, word_count, abort, byte_in, byte_valid,
        input  byte_ready, wr_en, wr_address, wr_data, busy, cpu_stall, done
    );

    modport slave (
        input  start, word_count, abort, byte_in, byte_valid,
        output byte_ready, wr_en, wr_address, wr_data, busy, cpu_stall, done
    );
endinterface

// File: rtl/imem_loader.sv
// Sequential instruction-memory writer: packs a big-endian byte stream into 32-bit words
// and writes them to consecutive word addresses from 0, stalling the CPU while loading.
module imem_loader #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state_r;
    state_t          state_nxt_s;
    logic [ADDR_W:0] target_r;
    logic [ADDR_W:0] target_nxt_s;
    logic [ADDR_W:0] word_cnt_r;
    logic [ADDR_W:0] word_cnt_nxt_s;
    logic [1:0]      byte_cnt_r;
    logic [1:0]      byte_cnt_nxt_s;
    logic [31:0]     asm_r;
    logic [31:0]     asm_nxt_s;

    logic            byte_ready_r;
    logic            wr_en_r;
    logic            busy_r;
    logic            done_r;
    logic [31:0]     wr_address_r;
    logic [31:0]     wr_data_r;

    // Next-state, word/byte counter and byte-assembly logic.
    always_comb begin
        state_nxt_s    = state_r;
        target_nxt_s   = target_r;
        word_cnt_nxt_s = word_cnt_r;
        byte_cnt_nxt_s = byte_cnt_r;
        asm_nxt_s      = asm_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    if ((bus.word_count == ZERO_C) || (bus.word_count > DEPTH_C)) begin
                        target_nxt_s = DEPTH_C;
                    end else begin
                        target_nxt_s = bus.word_count;
                    end
                    word_cnt_nxt_s = ZERO_C;
                    byte_cnt_nxt_s = 2'd0;
                    state_nxt_s    = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // Abort outranks a byte presented in the same cycle; that byte is dropped.
                if (bus.abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.byte_valid) begin
                    asm_nxt_s      = {asm_r[23:0], bus.byte_in};
                    byte_cnt_nxt_s = byte_cnt_r + 2'd1;
                    if (byte_cnt_r == 2'd3) begin
                        state_nxt_s = ST_WRITE;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_WRITE: begin
                word_cnt_nxt_s = word_cnt_r + ONE_C;
                byte_cnt_nxt_s = 2'd0;
                if (bus.abort) begin
                    state_nxt_s = ST_IDLE;
                end else if ((word_cnt_r + ONE_C) == target_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; outputs are decoded from the next state so they
    // line up with the state they describe while coming straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            target_r     <= ZERO_C;
            word_cnt_r   <= ZERO_C;
            byte_cnt_r   <= 2'd0;
            asm_r        <= 32'd0;
            byte_ready_r <= 1'b0;
            wr_en_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            wr_address_r <= 32'd0;
            wr_data_r    <= 32'd0;
        end else begin
            state_r      <= state_nxt_s;
            target_r     <= target_nxt_s;
            word_cnt_r   <= word_cnt_nxt_s;
            byte_cnt_r   <= byte_cnt_nxt_s;
            asm_r        <= asm_nxt_s;
            byte_ready_r <= (state_nxt_s == ST_LOAD);
            wr_en_r      <= (state_nxt_s == ST_WRITE);
            busy_r       <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_WRITE);
            done_r       <= (state_nxt_s == ST_DONE);
            // Address/data only move on entry to WRITE, so they hold the last write otherwise.
            if (state_nxt_s == ST_WRITE) begin
                wr_address_r <= {{(31 - ADDR_W){1'b0}}, word_cnt_nxt_s};
                wr_data_r    <= asm_nxt_s;
            end else begin
                wr_address_r <= wr_address_r;
                wr_data_r    <= wr_data_r;
            end
        end
    end

    assign bus.byte_ready = byte_ready_r;
    assign bus.wr_en      = wr_en_r;
    assign bus.wr_address = wr_address_r;
    assign bus.wr_data    = wr_data_r;
    assign bus.busy       = busy_r;
    assign bus.cpu_stall  = busy_r;
    assign bus.done       = done_r;
endmodule

// File: doc/imem_loader.md
# imem_loader

Sequential writer for the instruction memory. It receives a big-endian byte stream over a valid/ready handshake and assembles each group of four bytes into a 32-bit instruction. Each instruction is written to consecutive word addresses starting at 0. While a load is in progress it holds the CPU stalled; the instruction memory's combinational read port (word address in, instruction out) is unchanged.

## Interface
- DEPTH, 128: number of instruction words in memory; max words per load.
- ADDR_W, 7: width of word index; must satisfy 2^ADDR_W >= DEPTH.
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  begin a load; sampled in IDLE only.
- WordCount  input  ADDR_W+1  words to load, sampled with Start; 0 or >DEPTH loads DEPTH.
- Abort  input  1  terminate load; returns to IDLE without Done.
- ByteIn  input  8  stream byte.
- ByteValid  input  1  ByteIn is valid.
- ByteReady  output  1  loader accepts a byte this cycle.
- WrEn  output  1  instruction memory write enable.
- WrAddress  output  32  word index to write; upper bits zero.
- WrData  output  32  assembled instruction.
- Busy  output  1  load in progress.
- CpuStall  output  1  equals Busy.
- Done  output  1  one-cycle pulse after the last word is written.

## Operation
States: IDLE, LOAD, WRITE, DONE.
- IDLE
  - ByteReady=0, Busy=0.
  - Start=1: latch target = (WordCount==0 || WordCount>DEPTH) ? DEPTH : WordCount; clear word counter and byte counter; go to LOAD.
- LOAD
  - ByteReady=1.
  - Byte accepted when ByteValid&ByteReady at the rising edge: assembly <= {assembly[23:0], ByteIn}; byte counter (2 bits) increments.
  - On the 4th accepted byte, go to WRITE. The first byte received becomes bits 31:24.
- WRITE
  - ByteReady=0, WrEn=1, WrData=assembly, WrAddress=word counter.
  - Next edge: word counter increments. If the incremented count equals target, go to DONE; otherwise go to LOAD with byte counter=0.
- DONE
  - Done=1 for this single cycle; next state IDLE.
  - Written words remain in memory.
- Abort
  - Abort=1 in LOAD or WRITE: next state IDLE.
  - Abort has priority over the byte accept and over the transition out of WRITE; the write itself still occurs if WrEn is already high that cycle.
  - No Done pulse; partially assembled bytes are discarded.
- Start while Busy is ignored.
- Start and Abort together in IDLE: Abort wins, stay IDLE.
- Word counter is ADDR_W+1 bits and never wraps: target <= DEPTH guarantees termination at DEPTH.

## Timing
- Reset (Rst_n=0, asynchronous): state=IDLE; ByteReady=0, WrEn=0, WrAddress=0, WrData=0, Busy=0, CpuStall=0, Done=0; all counters and assembly cleared.
- Reset mid-load behaves identically; no Done.
- All outputs are derived from registered state and registers; no combinational path from input to output.
- Start edge to ByteReady=1: 1 cycle.
- Minimum cycles per word: 5 (4 LOAD + 1 WRITE). ByteReady drops during WRITE even if ByteValid stays high.
- A word load of N words with ByteValid held high: Start edge to Done=1 takes 5N+1 cycles.
- Busy and CpuStall are high from the cycle after Start through the last WRITE cycle, and low in the DONE cycle.
- WrAddress and WrData are held stable whenever WrEn=0 (last written values).

## Test plan
- Reset then idle: Rst_n low, then high, no Start -> all outputs 0, ByteReady stays 0 for 20 cycles.
- Single word: Start, WordCount=1, bytes 0x20,0x08,0x00,0x05 -> one WrEn pulse, WrAddress=0, WrData=0x20080005, Done pulse 6 cycles after Start, Busy low afterwards.
- Bursty stream: WordCount=3, ByteValid toggling 1/0 -> WrAddress 0,1,2 in order, correct data, no byte lost or duplicated, exactly one Done.
- Count clamp: WordCount=0, then WordCount=200, DEPTH=128 -> 128 writes each time, last WrAddress=127, then Done.
- Abort mid-word: after 2 bytes of word 1, Abort=1 -> IDLE next cycle, no WrEn for word 1, no Done; a new Start reloads from address 0.
- Async reset mid-load: Rst_n low during WRITE -> outputs 0 immediately (before the next clock edge), no Done; Start after release begins at address 0.
